// File: rtl/datapath_core.sv
// datapath_core: WIDTH-bit integer ALU with combinational result/flags and
// a one-cycle registered copy of result and flags for downstream status logic.
module datapath_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OpCode,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Neg,
    output logic             Carry,
    output logic             Overflow,
    output logic [WIDTH-1:0] Result_q,
    output logic [3:0]       Flags_q
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;

    // WIDTH always fits in WIDTH bits (WIDTH >= 2), so the modulus can be
    // carried at operand width.
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_shamt;
    logic             w_slt;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;

    logic [WIDTH-1:0] r_result_q;
    logic [3:0]       r_flags_q;

    // Shared arithmetic; shift amount is the full B reduced mod WIDTH, not a
    // truncated bit field, so non-power-of-two widths behave correctly.
    always_comb begin
        w_sum   = {1'b0, A} + {1'b0, B};
        w_diff  = {1'b0, A} - {1'b0, B};
        w_shamt = B % WIDTH_V;
        w_slt   = $signed(A) < $signed(B);
    end

    // Operation select; unsupported opcodes fall through to all-zero.
    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (OpCode)
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = (A[WIDTH-1] == B[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];   // borrow: A < B unsigned
                w_ovf    = (A[WIDTH-1] != B[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: w_result = A & B;
            OP_OR:  w_result = A | B;
            OP_XOR: w_result = A ^ B;
            OP_SLT: w_result = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLL: w_result = A << w_shamt;
            OP_SRL: w_result = A >> w_shamt;
            default: ;
        endcase
    end

    assign Result   = w_result;
    assign Zero     = (w_result == '0);
    assign Neg      = w_result[WIDTH-1];
    assign Carry    = w_carry;
    assign Overflow = w_ovf;

    // Registered copy of result and flags; reset wins over the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_q <= '0;
            r_flags_q  <= '0;
        end else begin
            r_result_q <= w_result;
            r_flags_q  <= {Zero, Neg, w_carry, w_ovf};
        end
    end

    assign Result_q = r_result_q;
    assign Flags_q  = r_flags_q;

endmodule

// File: tb/tb_datapath_core.sv
// Directed vector table, reset/register sequences and a random regression
// against an independent integer-arithmetic model for datapath_core.
module tb_datapath_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A, B;
    logic [3:0] OpCode;
    logic [7:0] Result, Result_q;
    logic       Zero, Neg, Carry, Overflow;
    logic [3:0] Flags_q;

    int n_tests = 0;
    int n_fail  = 0;

    datapath_core #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .OpCode(OpCode),
        .Result(Result), .Zero(Zero), .Neg(Neg), .Carry(Carry),
        .Overflow(Overflow), .Result_q(Result_q), .Flags_q(Flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;   // {Z,N,C,V}
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", name, got, exp);
        end
    endtask

    // Independent model: plain integer arithmetic, overflow by range check.
    function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, s, r, c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        r = 0; c = 0; v = 0;
        case (op)
            4'd0: begin s = ua + ub; r = s & 255; c = (s > 255) ? 1 : 0;
                        v = (sa + sb > 127 || sa + sb < -128) ? 1 : 0; end
            4'd1: begin s = ua - ub; r = s & 255; c = (ua < ub) ? 1 : 0;
                        v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0; end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = (sa < sb) ? 1 : 0;
            4'd6: r = (ua << (ub % 8)) & 255;
            4'd7: r = ua >> (ub % 8);
            default: r = 0;
        endcase
        model = {(r == 0) ? 1'b1 : 1'b0, (r >= 128) ? 1'b1 : 1'b0, c[0], v[0], r[7:0]};
    endfunction

    function automatic logic [11:0] comb_out();
        return {Zero, Neg, Carry, Overflow, Result};
    endfunction

    initial begin
        int hit_op[8];
        int slt_t, slt_f, c_hit, v_hit;
        logic [11:0] e;

        vecs[0]  = '{4'h0, 8'h05, 8'h03, 8'h08, 4'b0000};
        vecs[1]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 4'b1010};
        vecs[2]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 4'b0101};
        vecs[3]  = '{4'h1, 8'h0A, 8'h03, 8'h07, 4'b0000};
        vecs[4]  = '{4'h1, 8'h03, 8'h0A, 8'hF9, 4'b0110};
        vecs[5]  = '{4'h1, 8'h80, 8'h01, 8'h7F, 4'b0001};
        vecs[6]  = '{4'h2, 8'hF0, 8'h0F, 8'h00, 4'b1000};
        vecs[7]  = '{4'h3, 8'hAA, 8'h55, 8'hFF, 4'b0100};
        vecs[8]  = '{4'h4, 8'hC3, 8'h3C, 8'hFF, 4'b0100};
        vecs[9]  = '{4'h5, 8'h02, 8'h05, 8'h01, 4'b0000};
        vecs[10] = '{4'h5, 8'h80, 8'h01, 8'h01, 4'b0000};
        vecs[11] = '{4'h5, 8'h05, 8'h02, 8'h00, 4'b1000};
        vecs[12] = '{4'h5, 8'h01, 8'hFF, 8'h00, 4'b1000};
        vecs[13] = '{4'h6, 8'h0F, 8'h02, 8'h3C, 4'b0000};
        vecs[14] = '{4'h6, 8'h01, 8'h09, 8'h02, 4'b0000};
        vecs[15] = '{4'h7, 8'hF0, 8'h03, 8'h1E, 4'b0000};
        vecs[16] = '{4'h7, 8'h80, 8'h08, 8'h80, 4'b0100};
        vecs[17] = '{4'hA, 8'h5A, 8'hA5, 8'h00, 4'b1000};
        vecs[18] = '{4'hF, 8'hFF, 8'hFF, 8'h00, 4'b1000};
        vecs[19] = '{4'h0, 8'h80, 8'h80, 8'h00, 4'b1011};

        // Reset state
        rst = 1'b1; A = 8'h7F; B = 8'h01; OpCode = 4'h0;
        @(posedge clk); #1;
        chk("reset_regs", {Flags_q, Result_q}, 12'h000);
        chk("comb_during_reset", comb_out(), {4'b0101, 8'h80});
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_load_after_reset", {Flags_q, Result_q}, {4'b0101, 8'h80});

        // Directed table: combinational then registered copy
        for (int i = 0; i < 20; i++) begin
            OpCode = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            #1;
            chk($sformatf("vec%0d_comb", i), comb_out(), {vecs[i].flg, vecs[i].res});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_reg", i), {Flags_q, Result_q}, {vecs[i].flg, vecs[i].res});
        end

        // Mid-stream reset: registers clear, combinational path untouched
        OpCode = 4'h1; A = 8'h03; B = 8'h0A;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_regs", {Flags_q, Result_q}, 12'h000);
        chk("midreset_comb", comb_out(), {4'b0110, 8'hF9});
        rst = 1'b0;
        OpCode = 4'h0; A = 8'h7F; B = 8'h01;
        @(posedge clk); #1;
        chk("release_load", {Flags_q, Result_q}, {4'b0101, 8'h80});

        // Random regression
        for (int k = 0; k < 8; k++) hit_op[k] = 0;
        slt_t = 0; slt_f = 0; c_hit = 0; v_hit = 0;
        for (int i = 0; i < 2000; i++) begin
            OpCode = 4'($urandom_range(0, 7));
            A = 8'($urandom); B = 8'($urandom);
            e = model(OpCode, A, B);
            hit_op[OpCode[2:0]]++;
            if (OpCode == 4'h5) begin
                if (e[0]) slt_t++; else slt_f++;
            end
            if (e[9])  c_hit++;
            if (e[8])  v_hit++;
            #1;
            chk($sformatf("rand%0d_comb op%0h a%02h b%02h", i, OpCode, A, B), comb_out(), e);
            @(posedge clk); #1;
            chk($sformatf("rand%0d_reg", i), {Flags_q, Result_q}, e);
        end
        for (int k = 0; k < 8; k++)
            chk($sformatf("cov_op%0d_hit", k), {11'd0, hit_op[k] > 0}, 12'd1);
        chk("cov_slt_true",  {11'd0, slt_t > 0}, 12'd1);
        chk("cov_slt_false", {11'd0, slt_f > 0}, 12'd1);
        chk("cov_carry",     {11'd0, c_hit > 0}, 12'd1);
        chk("cov_overflow",  {11'd0, v_hit > 0}, 12'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
- Parameterised integer ALU for the execution stage: ADD, SUB, AND, OR, XOR, signed SLT, SLL and SRL on two WIDTH-bit operands.
- Produces Zero, Neg, Carry and Overflow flags.
- The primary result and flags are purely combinational, with zero latency.
- A one-stage registered copy of result and flags, on clk with synchronous active-high reset rst, feeds downstream pipeline/status logic.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2.

Ports:
clk  input  1  system clock; rising edge; drives only the registered copy
rst  input  1  synchronous, active-high reset
A  input  WIDTH  operand A
B  input  WIDTH  operand B; for shift ops it supplies the shift amount
OpCode  input  4  operation select
Result  output  WIDTH  combinational result
Zero  output  1  combinational: Result == 0
Neg  output  1  combinational: Result[WIDTH-1]
Carry  output  1  combinational carry/borrow
Overflow  output  1  combinational signed overflow
Result_q  output  WIDTH  registered Result
Flags_q  output  4  registered flags {Zero, Neg, Carry, Overflow}, MSB first

Behaviour:
- Combinational path: Result and all four flags settle within the same delta/cycle as A, B or OpCode change. No clock is involved.
- Default for every op: Carry = 0, Overflow = 0, unless the op below says otherwise.
- 0000 ADD:
  - Compute a WIDTH+1-bit sum of A+B. Result = low WIDTH bits; Carry = bit WIDTH.
  - Overflow = (A[MSB] == B[MSB]) and (Result[MSB] != A[MSB]).
- 0001 SUB:
  - Compute a WIDTH+1-bit A-B. Result = low WIDTH bits; Carry = bit WIDTH, which is a borrow: 1 exactly when A < B unsigned.
  - Overflow = (A[MSB] != B[MSB]) and (Result[MSB] != A[MSB]).
- 0010 AND: Result = A & B.
- 0011 OR: Result = A | B.
- 0100 XOR: Result = A ^ B.
- 0101 SLT: Result = 1 (zero-extended) if signed(A) < signed(B), else 0.
- 0110 SLL: Result = A << (B mod WIDTH), logical, zero fill.
- 0111 SRL: Result = A >> (B mod WIDTH), logical, zero fill.
  - Shift amount is the unsigned value of the full B modulo WIDTH; it is not the raw B. For power-of-two WIDTH this equals B[clog2(WIDTH)-1:0].
- 1000-1111 (unsupported): Result = 0, Carry = 0, Overflow = 0, hence Zero = 1 and Neg = 0.
- Zero = (Result == 0) and Neg = Result[WIDTH-1] for all opcodes, including logic, SLT and shift ops.
- Registered path:
  - On every rising clk edge, Result_q <= Result and Flags_q <= {Zero, Neg, Carry, Overflow}.
  - Latency is 1 cycle. There is no enable and no handshake.
- Reset:
  - If rst = 1 at a rising edge, Result_q = 0 and Flags_q = 0 for that edge; rst has priority over the load.
  - Reset mid-operation never affects the combinational outputs.
  - After rst deasserts, the first edge loads the live values.
- Outputs must never be X or Z when all inputs are known.

Test Plan:
- ADD: A=05, B=03 -> Result=08, Z=0 N=0 C=0 V=0. ADD: A=FF, B=01 -> Result=00, Z=1, C=1, V=0. ADD: A=7F, B=01 -> Result=80, N=1, V=1, C=0.
- SUB: A=0A, B=03 -> Result=07, C=0, V=0. SUB: A=03, B=0A -> Result=F9, N=1, C=1. SUB: A=80, B=01 -> Result=7F, V=1.
- Logic ops:
  - AND F0&0F -> 00, Z=1.
  - OR AA|55 -> FF, N=1.
  - XOR C3^3C -> FF.
  - In all three cases C=V=0.
- SLT: A=02, B=05 -> 01. SLT: A=80, B=01 -> 01 (signed). SLT: A=05, B=02 -> 00, Z=1. SLT: A=01, B=FF -> 00.
- Shifts (C=V=0 throughout):
  - SLL: A=0F, B=02 -> 3C.
  - SLL: A=01, B=09 -> 02 (9 mod 8).
  - SRL: A=F0, B=03 -> 1E.
  - SRL: A=80, B=08 -> 80 (shift 0).
- Unsupported and registered path:
  - OpCode=1010 with any A, B -> Result=00, Z=1, others 0.
  - Assert rst for 1 edge -> Result_q=00, Flags_q=0000.
  - Release rst, apply ADD 7F+01 -> after the next edge Result_q=80, Flags_q=0101.
- Random regression: at least 2000 random {A, B, OpCode 0-7} vectors compared against a golden model, with zero mismatches.
- Coverage goals for the random regression: every op hit, SLT both true and false, Carry=1 and Overflow=1 each hit.
